controle_temporizador: RTL and testbench
========================================

# controle_temporizador

Control FSM for the two-digit (00–99) countdown timer. It sits directly upstream of the cascaded units/tens decimal down counters. It produces their load strobe and per-digit count enables from a divided tick, watches their terminal-count flags to detect expiry, and reports timer state. The counters hold the digit values; this block decides when they load, when they count and when the run ends.

## Interface
Parameters:
- DIV, default 50_000_000: clock cycles per count tick. Must be ≥ 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse (debounced upstream): begin, resume or restart.
- pause  in  1  one-cycle pulse: suspend counting.
- clear  in  1  one-cycle pulse: abort and return to idle.
- tc_unid  in  1  terminal count from the units counter (1 when units = 0).
- tc_dez  in  1  terminal count from the tens counter (1 when tens = 0).
- load  out  1  load strobe to both counters (loads user digits).
- en_unid  out  1  count enable to the units counter (drives its run/stop input; 1 = decrement).
- en_dez  out  1  count enable to the tens counter.
- done  out  1  timer expired; held until clear or start.
- estado  out  3  current state code, for display/debug.

## Operation
- State codes: OCIOSO=0, CARREGA=1, CONTANDO=2, PAUSADO=3, FIM=4.
- Command priority in any cycle: clear > start > pause.
- Transitions:
  - OCIOSO: start → CARREGA.
  - CARREGA: unconditional → CONTANDO. This is the only state asserting load. clear → OCIOSO still wins.
  - CONTANDO:
    - clear → OCIOSO.
    - pause → PAUSADO.
    - tc_unid & tc_dez (both digits 0) → FIM.
    - start: ignored.
  - PAUSADO: start → CONTANDO (resume); clear → OCIOSO; pause ignored.
  - FIM: start → CARREGA (restart with current data); clear → OCIOSO.
- Prescaler: counts 0..DIV−1 only in CONTANDO, wrapping to 0. Tick = prescaler at DIV−1 while in CONTANDO.
  - Cleared in CARREGA and OCIOSO.
  - Held (not cleared) in PAUSADO, so resume keeps the partial period.
- Enables, combinational from registered state and prescaler:
  - en_unid = tick & ~(tc_unid & tc_dez).
  - en_dez = en_unid & tc_unid (borrow: tens decrement only when units wrap 0→9).
- Both enables are 0 outside CONTANDO, and 0 when pause or clear is present in that cycle.
- done = (state == FIM).
- Width rule: prescaler width = $clog2(DIV). No other arithmetic.

## Timing
- Reset (reset=0 at an edge): state OCIOSO, prescaler 0. Outputs load=0, en_unid=0, en_dez=0, done=0, estado=0.
- Reset mid-run takes priority over everything and aborts immediately.
- Latencies:
  - start in OCIOSO at edge k → load=1 during cycle k+1.
  - CONTANDO from k+2; first tick at cycle k+2+DIV−1.
- Counter decrements on the edge ending a cycle where its enable=1.
- Expiry: the cycle after the counters reach 00, the FSM sees both tc flags → FIM next edge → done=1.
  - Loaded value 00 → FIM one cycle after entering CONTANDO; no enable ever issued.
- Simultaneous tick and pause: pause wins, no decrement, prescaler frozen at DIV−1. The tick fires on the first CONTANDO cycle after resume.
- Simultaneous start and clear: clear wins.
- Outputs are functions of registered state/prescaler plus same-cycle command masking. No combinational path from tc_* to load.

## Structure
- Shared package: state encoding constants (OCIOSO..FIM) and the 3-bit state width, so the display decoder uses the same codes.
- One natural sub-module: divisor_tick (parameter DIV; inputs clk, reset, run, clr; output tick). Everything else (FSM, enable logic) stays in the top module.

## Test plan (DIV=4; behavioural model of two counters attached)
- Reset, then start with data 12 → load pulse 1 cycle after start. Units decrement every 4 cycles; tens go 1→0 when units wrap 0→9. done=1 two cycles after count reaches 00; total run ≈ 12×4 cycles.
- Load 00, start → FIM reached with en_unid never asserted; estado sequence 0→1→2→4.
- Load 05, pause after 2 ticks, wait 20 cycles, start → count stays 03 during pause. Next tick arrives after the remaining prescaler cycles, not a full period.
- Pause asserted exactly on the tick cycle → no decrement on that cycle; decrement occurs on the first CONTANDO cycle after resume.
- start and clear in the same cycle while CONTANDO → OCIOSO, enables 0, done=0.
- reset=0 during CONTANDO and during FIM → next edge all outputs 0 and estado=0. A start in the same cycle as reset=0 is ignored.

Source files
------------

// File: rtl/controle_temporizador_pkg.sv
// controle_temporizador_pkg
//   Shared definitions for the two-digit countdown timer controller.
//   The state codes are also what the display/debug decoder reads on estado,
//   so any consumer of estado should import this package rather than
//   hard-coding the numbers.
package controle_temporizador_pkg;

   localparam int unsigned ESTADO_W = 3;

   typedef enum logic [ESTADO_W-1:0] {
      OCIOSO   = 3'd0,
      CARREGA  = 3'd1,
      CONTANDO = 3'd2,
      PAUSADO  = 3'd3,
      FIM      = 3'd4
   } estado_t;

endpackage

// File: rtl/controle_temporizador_if.sv
// controle_temporizador_if
//   Command / counter-handshake bundle between the timer controller and
//   its surroundings (debounced buttons, cascaded decimal down counters).
//   Signals:
//     start, pause, clear  one-cycle command pulses
//     tc_unid, tc_dez      terminal-count flags from the units/tens counters
//     load                 load strobe to both counters
//     en_unid, en_dez      per-digit count enables
//     done                 timer expired
//     estado               current state code
//   Modports:
//     master  side that drives commands and counter flags
//     slave   the controller
interface controle_temporizador_if;
   import controle_temporizador_pkg::*;

   logic                start;
   logic                pause;
   logic                clear;
   logic                tc_unid;
   logic                tc_dez;
   logic                load;
   logic                en_unid;
   logic                en_dez;
   logic                done;
   logic [ESTADO_W-1:0] estado;

   modport master (
      output start, pause, clear, tc_unid, tc_dez,
      input  load, en_unid, en_dez, done, estado
   );

   modport slave (
      input  start, pause, clear, tc_unid, tc_dez,
      output load, en_unid, en_dez, done, estado
   );

endinterface

// File: rtl/controle_temporizador_divisor_tick.sv
// divisor_tick
//   Prescaler producing the count tick for the timer.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-low reset (clears the prescaler)
//     run    advance the prescaler this cycle
//     clr    force the prescaler back to 0 (used outside a run)
//     tick   1 on the cycle the prescaler sits at DIV-1 while running
//   With run=0 and clr=0 the prescaler holds, which lets a paused run keep
//   its partial period.
module divisor_tick #(
   parameter int unsigned DIV = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clr,
   output logic tick
);

   localparam int unsigned   W      = $clog2(DIV);
   localparam logic [W-1:0]  ULTIMO = W'(DIV - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (run) begin
         r_cnt <= (r_cnt == ULTIMO) ? '0 : r_cnt + 1'b1;
      end
   end

   // Gated by run so a pause/clear on the terminal cycle freezes the
   // prescaler at DIV-1 and the tick is replayed on resume.
   assign tick = run & (r_cnt == ULTIMO);

endmodule

// File: rtl/controle_temporizador.sv
// controle_temporizador
//   Control FSM for the 00-99 countdown timer. Drives the load strobe and
//   per-digit count enables of the cascaded units/tens down counters from a
//   divided tick, watches their terminal-count flags to detect expiry and
//   reports its state.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-low reset
//     bus    controle_temporizador_if.slave (commands, counter flags,
//            load/enables, done, estado)
//   Parameter:
//     DIV    clock cycles per count tick (>= 2)
module controle_temporizador #(
   parameter int unsigned DIV = 50_000_000
) (
   input logic                     clk,
   input logic                     reset,
   controle_temporizador_if.slave  bus
);
   import controle_temporizador_pkg::*;

   estado_t r_estado;
   estado_t w_prox;
   logic    r_load;
   logic    r_done;
   logic    w_run;
   logic    w_clr;
   logic    w_tick;
   logic    w_zero;
   logic    w_en_unid;

   assign w_zero = bus.tc_unid & bus.tc_dez;

   // Prescaler only advances in CONTANDO with no pause/clear present, so the
   // tick (and both enables) are masked by those commands in the same cycle.
   assign w_run = (r_estado == CONTANDO) & ~bus.pause & ~bus.clear;
   assign w_clr = (r_estado == OCIOSO) | (r_estado == CARREGA);

   divisor_tick #(
      .DIV (DIV)
   ) u_divisor (
      .clk   (clk),
      .reset (reset),
      .run   (w_run),
      .clr   (w_clr),
      .tick  (w_tick)
   );

   always_comb begin
      w_prox = r_estado;
      case (r_estado)
         OCIOSO: begin
            if (bus.start && !bus.clear) w_prox = CARREGA;
         end
         CARREGA: begin
            w_prox = bus.clear ? OCIOSO : CONTANDO;
         end
         CONTANDO: begin
            if (bus.clear)      w_prox = OCIOSO;
            else if (bus.pause) w_prox = PAUSADO;
            else if (w_zero)    w_prox = FIM;
         end
         PAUSADO: begin
            if (bus.clear)      w_prox = OCIOSO;
            else if (bus.start) w_prox = CONTANDO;
         end
         FIM: begin
            if (bus.clear)      w_prox = OCIOSO;
            else if (bus.start) w_prox = CARREGA;
         end
         default: w_prox = OCIOSO;
      endcase
   end

   // load and done are decoded from the next state so they line up with the
   // registered state code without a combinational path from tc_*.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_estado <= OCIOSO;
         r_load   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_estado <= w_prox;
         r_load   <= (w_prox == CARREGA);
         r_done   <= (w_prox == FIM);
      end
   end

   // Tens borrow only when the units digit wraps 0 -> 9.
   assign w_en_unid   = w_tick & ~w_zero;
   assign bus.en_unid = w_en_unid;
   assign bus.en_dez  = w_en_unid & bus.tc_unid;
   assign bus.load    = r_load;
   assign bus.done    = r_done;
   assign bus.estado  = r_estado;

endmodule

// File: tb/tb_controle_temporizador.sv
// tb_controle_temporizador
//   Bench for controle_temporizador with DIV=4. Two decimal down counters are
//   attached to the DUT enables; a behavioural model tracks the remaining
//   count as a single integer and predicts every output each cycle.
module tb_controle_temporizador;

   localparam int unsigned DIV = 4;

   logic clk;
   logic reset;

   controle_temporizador_if u_if ();

   controle_temporizador #(
      .DIV (DIV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;

   int data_u = 0;
   int data_t = 0;
   int env_u  = 0;
   int env_t  = 0;

   // attached counters (driven by the DUT's own strobes)
   assign u_if.tc_unid = (env_u == 0);
   assign u_if.tc_dez  = (env_t == 0);

   always @(posedge clk) begin
      if (chk_en) begin
         if (u_if.load) begin
            env_u <= data_u;
            env_t <= data_t;
         end else begin
            if (u_if.en_unid) env_u <= (env_u == 0) ? 9 : env_u - 1;
            if (u_if.en_dez)  env_t <= (env_t == 0) ? 9 : env_t - 1;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // model: st = state code, ph = cycles into the current tick period,
   // n = value held by the counters as a plain number 0..99
   int m_st = 0;
   int m_ph = 0;
   int m_n  = 0;
   logic m_tick, m_en_u, m_en_d, m_zero;

   always @(negedge clk) begin
      if (chk_en) begin
         m_tick = (m_st == 2) && (m_ph == DIV - 1) && !u_if.pause && !u_if.clear;
         m_en_u = m_tick && (m_n != 0);
         m_en_d = m_en_u && (m_n % 10 == 0);
         chk("estado",  int'(u_if.estado), m_st);
         chk("load",    int'(u_if.load),    int'(m_st == 1));
         chk("done",    int'(u_if.done),    int'(m_st == 4));
         chk("en_unid", int'(u_if.en_unid), int'(m_en_u));
         chk("en_dez",  int'(u_if.en_dez),  int'(m_en_d));

         m_zero = (m_n == 0);
         if (m_en_u)    m_n = m_n - 1;
         if (m_st == 1) m_n = 10 * data_t + data_u;

         if (!reset) begin
            m_st = 0;
            m_ph = 0;
         end else begin
            case (m_st)
               0: begin
                  m_ph = 0;
                  if (u_if.start && !u_if.clear) m_st = 1;
               end
               1: begin
                  m_ph = 0;
                  m_st = u_if.clear ? 0 : 2;
               end
               2: begin
                  if (u_if.clear)      m_st = 0;
                  else if (u_if.pause) m_st = 3;
                  else begin
                     m_ph = (m_ph + 1) % DIV;
                     if (m_zero) m_st = 4;
                  end
               end
               3: begin
                  if (u_if.clear)      m_st = 0;
                  else if (u_if.start) m_st = 2;
               end
               default: begin
                  if (u_if.clear)      m_st = 0;
                  else if (u_if.start) m_st = 1;
               end
            endcase
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      u_if.start = 1'b1;
      sync();
      u_if.start = 1'b0;
   endtask

   task automatic pulse_clear();
      u_if.clear = 1'b1;
      sync();
      u_if.clear = 1'b0;
   endtask

   int n;
   int cnt;
   logic seen;

   initial begin
      reset      = 1'b0;
      u_if.start = 1'b0;
      u_if.pause = 1'b0;
      u_if.clear = 1'b0;
      sync();
      sync();
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_estado",  int'(u_if.estado),  0);
      chk("rst_load",    int'(u_if.load),    0);
      chk("rst_done",    int'(u_if.done),    0);
      chk("rst_en_unid", int'(u_if.en_unid), 0);
      sync();
      reset = 1'b1;

      // run of 12: load one cycle after start, done 51 cycles after start edge
      data_t = 1; data_u = 2;
      sync();
      pulse_start();
      n = 0;
      for (int i = 1; i <= 200 && n == 0; i++) begin
         @(negedge clk);
         if (i == 1) chk("t1_load_latency", int'(u_if.load), 1);
         if (u_if.done) n = i;
      end
      chk("t1_done_latency", n, 51);
      chk("t1_model_zero", m_n, 0);

      // loaded 00: estado 0 -> 1 -> 2 -> 4, no enable
      sync();
      pulse_clear();
      @(negedge clk);
      chk("t2_idle", int'(u_if.estado), 0);
      data_t = 0; data_u = 0;
      sync();
      pulse_start();
      seen = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (u_if.en_unid) seen = 1'b1;
         if (i == 1) chk("t2_seq1", int'(u_if.estado), 1);
         if (i == 2) chk("t2_seq2", int'(u_if.estado), 2);
         if (i == 3) chk("t2_seq3", int'(u_if.estado), 4);
      end
      chk("t2_no_enable", int'(seen), 0);

      // load 05 from FIM, pause after 2 ticks with one partial cycle banked
      sync();
      data_u = 5;
      pulse_start();
      cnt = 0; n = 0;
      for (int i = 1; i <= 100 && cnt < 2; i++) begin
         @(negedge clk);
         if (u_if.en_unid) begin
            cnt++;
            if (cnt == 2) n = i;
         end
      end
      chk("t3_second_tick", n, 9);
      sync();
      sync();
      u_if.pause = 1'b1;
      sync();
      u_if.pause = 1'b0;
      repeat (20) sync();
      @(negedge clk);
      chk("t3_paused_state", int'(u_if.estado), 3);
      chk("t3_paused_units", env_u, 3);
      chk("t3_model_count", m_n, 3);
      sync();
      pulse_start();
      n = 0;
      for (int i = 1; i <= 20 && n == 0; i++) begin
         @(negedge clk);
         if (u_if.en_unid) n = i;
      end
      chk("t3_resume_partial", n, 3);

      // pause exactly on the tick cycle
      repeat (4) sync();
      u_if.pause = 1'b1;
      @(negedge clk);
      chk("t4_tick_masked", int'(u_if.en_unid), 0);
      sync();
      u_if.pause = 1'b0;
      repeat (3) sync();
      @(negedge clk);
      chk("t4_units_held", env_u, 2);
      sync();
      pulse_start();
      @(negedge clk);
      chk("t4_resume_tick", int'(u_if.en_unid), 1);

      // start + clear together while counting
      sync();
      u_if.start = 1'b1;
      u_if.clear = 1'b1;
      sync();
      u_if.start = 1'b0;
      u_if.clear = 1'b0;
      @(negedge clk);
      chk("t5_estado", int'(u_if.estado),  0);
      chk("t5_en_unid", int'(u_if.en_unid), 0);
      chk("t5_done", int'(u_if.done), 0);

      // reset during CONTANDO with a start in the same cycle
      sync();
      data_t = 1; data_u = 2;
      pulse_start();
      repeat (10) sync();
      reset      = 1'b0;
      u_if.start = 1'b1;
      sync();
      reset      = 1'b1;
      u_if.start = 1'b0;
      @(negedge clk);
      chk("t6_run_reset_estado", int'(u_if.estado), 0);
      chk("t6_run_reset_load", int'(u_if.load), 0);
      repeat (3) sync();
      @(negedge clk);
      chk("t6_start_ignored", int'(u_if.estado), 0);

      // reset during FIM
      data_t = 0; data_u = 0;
      sync();
      pulse_start();
      repeat (4) sync();
      @(negedge clk);
      chk("t6_fim_done", int'(u_if.done), 1);
      sync();
      reset = 1'b0;
      sync();
      reset = 1'b1;
      @(negedge clk);
      chk("t6_fim_reset_done", int'(u_if.done), 0);
      chk("t6_fim_reset_estado", int'(u_if.estado), 0);

      // random commands, data and occasional reset
      for (int c = 0; c < 3000; c++) begin
         sync();
         u_if.start = ($urandom_range(0, 99) < 6);
         u_if.pause = ($urandom_range(0, 99) < 4);
         u_if.clear = ($urandom_range(0, 99) < 2);
         reset      = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 19) == 0) begin
            data_u = $urandom_range(0, 9);
            data_t = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 1);
         end
      end
      sync();
      u_if.start = 1'b0;
      u_if.pause = 1'b0;
      u_if.clear = 1'b0;
      reset      = 1'b1;
      @(negedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
